// File: rtl/job_q_2_1_sweep_ctrl_if.sv
// Bundle between the sweep sequencer, its control logic and the job_q_2_1 instance.
// Optional first-failure fields exist only when FIRST_FAIL_EN is defined.
interface job_q_2_1_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        input_a;
  logic        input_b;
  logic        input_c;
  logic        input_d;
  logic        output_y;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic        pass;
  logic [4:0]  mismatch_count;
`ifdef FIRST_FAIL_EN
  logic        first_fail_valid;
  logic [3:0]  first_fail_idx;
`endif

  modport master (
    output start, abort, output_y,
    input  input_a, input_b, input_c, input_d,
    input  busy, done, truth_table, pass, mismatch_count
`ifdef FIRST_FAIL_EN
    , input first_fail_valid, first_fail_idx
`endif
  );

  modport slave (
    input  start, abort, output_y,
    output input_a, input_b, input_c, input_d,
    output busy, done, truth_table, pass, mismatch_count
`ifdef FIRST_FAIL_EN
    , output first_fail_valid, first_fail_idx
`endif
  );
endinterface

// File: rtl/job_q_2_1_sweep_ctrl.sv
// Sweeps all 16 vectors through job_q_2_1, captures its truth table and grades it.
// Define FIRST_FAIL_EN to also record the index of the first mismatching vector.
module job_q_2_1_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'h6996
) (
  input logic             clk_sys_i,
  input logic             rst_i,
  job_q_2_1_sweep_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | driving vectors, sampling output_y
  // CHECK | grading captured table, one cycle
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] tt_q, tt_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [4:0]  mc_q, mc_d;
`ifdef FIRST_FAIL_EN
  logic        ff_valid_q, ff_valid_d;
  logic [3:0]  ff_idx_q, ff_idx_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    tt_d     = tt_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mc_d     = mc_q;
`ifdef FIRST_FAIL_EN
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d    = 4'd0;
          settle_d = SETTLE_RELOAD;
          tt_d     = 16'h0000;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          mc_d     = 5'd0;
`ifdef FIRST_FAIL_EN
          ff_valid_d = 1'b0;
          ff_idx_d   = 4'd0;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        // abort wins over a sample due on the same edge
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else begin
          tt_d[idx_q] = bus.output_y;
`ifdef FIRST_FAIL_EN
          if (!ff_valid_q && (bus.output_y != EXPECTED[idx_q])) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = idx_q;
          end
`endif
          if (idx_q == 4'd15) begin
            state_d = CHECK;
          end else begin
            idx_d    = idx_q + 4'd1;
            settle_d = SETTLE_RELOAD;
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (bus.abort) begin
          done_d = 1'b0;
          pass_d = 1'b0;
        end else begin
          pass_d = (tt_q == EXPECTED);
          mc_d   = 5'($countones(tt_q ^ EXPECTED));
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      settle_q <= 8'd0;
      tt_q     <= 16'h0000;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mc_q     <= 5'd0;
`ifdef FIRST_FAIL_EN
      ff_valid_q <= 1'b0;
      ff_idx_q   <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      tt_q     <= tt_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mc_q     <= mc_d;
`ifdef FIRST_FAIL_EN
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
`endif
    end
  end

  // vector comes straight off the index register to keep the DUT inputs glitch-free
  assign bus.input_a        = idx_q[3];
  assign bus.input_b        = idx_q[2];
  assign bus.input_c        = idx_q[1];
  assign bus.input_d        = idx_q[0];
  assign bus.busy           = (state_q == RUN) || (state_q == CHECK);
  assign bus.done           = done_q;
  assign bus.truth_table    = tt_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mc_q;
`ifdef FIRST_FAIL_EN
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_idx   = ff_idx_q;
`endif

endmodule

// File: tb/tb_job_q_2_1_sweep_ctrl.sv
// Randomized bench for the sweep sequencer: one instance with one-cycle settle, one with three,
// each feeding a table-driven stand-in for job_q_2_1, graded against a truth-table model.
module tb_job_q_2_1_sweep_ctrl;

  localparam logic [15:0] GOLD = 16'h6996;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        sel;
  logic        start_v, abort_v;
  logic [15:0] tbl1, tbl3;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  job_q_2_1_sweep_ctrl_if if1();
  job_q_2_1_sweep_ctrl_if if3();

  assign if1.start    = start_v & ~sel;
  assign if1.abort    = abort_v & ~sel;
  assign if3.start    = start_v & sel;
  assign if3.abort    = abort_v & sel;
  assign if1.output_y = tbl1[{if1.input_a, if1.input_b, if1.input_c, if1.input_d}];
  assign if3.output_y = tbl3[{if3.input_a, if3.input_b, if3.input_c, if3.input_d}];

  job_q_2_1_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(GOLD)) u_dut1 (
    .clk_sys_i(clk_sys), .rst_i(rst), .bus(if1));
  job_q_2_1_sweep_ctrl #(.SETTLE_CYCLES(3), .EXPECTED(GOLD)) u_dut3 (
    .clk_sys_i(clk_sys), .rst_i(rst), .bus(if3));

  wire [3:0]  vec_w  = sel ? {if3.input_a, if3.input_b, if3.input_c, if3.input_d}
                           : {if1.input_a, if1.input_b, if1.input_c, if1.input_d};
  wire        busy_w = sel ? if3.busy : if1.busy;
  wire        done_w = sel ? if3.done : if1.done;
  wire        pass_w = sel ? if3.pass : if1.pass;
  wire [15:0] tt_w   = sel ? if3.truth_table : if1.truth_table;
  wire [4:0]  mc_w   = sel ? if3.mismatch_count : if1.mismatch_count;
`ifdef FIRST_FAIL_EN
  wire        ffv_w  = sel ? if3.first_fail_valid : if1.first_fail_valid;
  wire [3:0]  ffi_w  = sel ? if3.first_fail_idx : if1.first_fail_idx;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount16(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n++;
    return n;
  endfunction

  // first vector below limit whose response differs from golden; {valid, idx}
  function automatic logic [4:0] first_fail(input logic [15:0] tbl, input int limit);
    logic [15:0] g = GOLD;
    for (int i = 0; i < limit; i++)
      if (tbl[i] != g[i]) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  function automatic logic [15:0] low_mask(input int n);
    logic [15:0] m = 16'h0000;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic load_tbl(input logic s, input logic [15:0] tbl);
    sel = s;
    if (s) tbl3 = tbl; else tbl1 = tbl;
  endtask

  // called at a negedge with the selected instance idle
  task automatic do_sweep(input logic s, input logic [15:0] tbl, input bit restart, input bit abort_too);
    int st = s ? 3 : 1;
    load_tbl(s, tbl);
    start_v = 1'b1;
    abort_v = abort_too;
    @(negedge clk_sys);
    start_v = 1'b0;
    abort_v = 1'b0;
    for (int c = 0; c < 16 * st; c++) begin
      chk("vector", 32'(vec_w), 32'(c / st));
      chk("busy_run", 32'(busy_w), 32'd1);
      chk("done_low", 32'(done_w), 32'd0);
      start_v = restart && (c == 5 * st || c == 10 * st);
      @(negedge clk_sys);
    end
    start_v = 1'b0;
    chk("busy_check", 32'(busy_w), 32'd1);
    chk("done_check", 32'(done_w), 32'd0);
    @(negedge clk_sys);
    chk("done", 32'(done_w), 32'd1);
    chk("busy_end", 32'(busy_w), 32'd0);
    chk("truth_table", 32'(tt_w), 32'(tbl));
    chk("pass", 32'(pass_w), 32'(tbl == GOLD));
    chk("mismatch_count", 32'(mc_w), 32'(popcount16(tbl ^ GOLD)));
    chk("vector_hold", 32'(vec_w), 32'd15);
`ifdef FIRST_FAIL_EN
    chk("first_fail", 32'({ffv_w, ffi_w}), 32'(first_fail(tbl, 16)));
`endif
  endtask

  // abort during the last cycle of vector at, before its sample lands
  task automatic do_abort(input logic s, input logic [15:0] tbl, input int at);
    int st = s ? 3 : 1;
    load_tbl(s, tbl);
    start_v = 1'b1;
    @(negedge clk_sys);
    start_v = 1'b0;
    for (int c = 0; c < at * st + st - 1; c++) @(negedge clk_sys);
    chk("vector_pre_abort", 32'(vec_w), 32'(at));
    abort_v = 1'b1;
    @(negedge clk_sys);
    abort_v = 1'b0;
    chk("abort_busy", 32'(busy_w), 32'd0);
    chk("abort_done", 32'(done_w), 32'd0);
    chk("abort_pass", 32'(pass_w), 32'd0);
    chk("abort_tt", 32'(tt_w), 32'(tbl & low_mask(at)));
    chk("abort_vector", 32'(vec_w), 32'(at));
`ifdef FIRST_FAIL_EN
    chk("abort_first_fail", 32'({ffv_w, ffi_w}), 32'(first_fail(tbl, at)));
`endif
    @(negedge clk_sys);
    chk("abort_stays_idle", 32'(busy_w), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vector"}, 32'(vec_w), 32'd0);
    chk({tag, "_busy"}, 32'(busy_w), 32'd0);
    chk({tag, "_done"}, 32'(done_w), 32'd0);
    chk({tag, "_tt"}, 32'(tt_w), 32'd0);
    chk({tag, "_pass"}, 32'(pass_w), 32'd0);
    chk({tag, "_mc"}, 32'(mc_w), 32'd0);
`ifdef FIRST_FAIL_EN
    chk({tag, "_ff"}, 32'({ffv_w, ffi_w}), 32'd0);
`endif
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    start_v = 1'b0;
    abort_v = 1'b0;
    tbl1    = GOLD;
    tbl3    = GOLD;
    repeat (3) @(negedge clk_sys);
    chk_reset_vals("reset1");
    sel = 1'b1;
    #1 chk_reset_vals("reset3");
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);

    do_sweep(1'b0, GOLD, 1'b0, 1'b0);
    do_sweep(1'b0, 16'h0000, 1'b0, 1'b0);
    do_sweep(1'b1, GOLD, 1'b0, 1'b0);
    do_sweep(1'b0, GOLD, 1'b1, 1'b0);
    do_abort(1'b0, GOLD, 7);
    do_sweep(1'b0, GOLD, 1'b0, 1'b1);

    // asynchronous reset while vector 9 is on the bus
    load_tbl(1'b0, GOLD);
    start_v = 1'b1;
    @(negedge clk_sys);
    start_v = 1'b0;
    repeat (9) @(negedge clk_sys);
    chk("vector_pre_reset", 32'(vec_w), 32'd9);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midreset");
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    do_sweep(1'b0, GOLD, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic        s;
      logic [15:0] t;
      s = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 3) == 0) ? GOLD : 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        do_abort(s, t, $urandom_range(0, 15));
      else
        do_sweep(s, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
